fetch_pc_gen: RTL and testbench

Fetch-stage PC generator. Holds the fetch PC and issues word-aligned instruction-fetch requests to instruction memory with a valid/ready handshake. It predicts sequential fetch by default. It redirects on EXE branch/jump/xRET results, where the next PC differs from the fall-through address, and on trap vectors from the CSR/trap logic. Each request is tagged with an epoch bit so downstream stages can discard wrong-path instructions.

---
 rtl/fetch_pc_gen_if.sv | 28 ++
 rtl/fetch_pc_gen.sv | 152 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - instruction-fetch request bus between PC generator and instruction memory
interface fetch_pc_gen_if #(
    parameter int PC_SZ = 32
);
    logic             ic_req_valid_out;
    logic             ic_req_ready_in;
    logic [PC_SZ-1:0] ic_req_addr_out;
    logic [PC_SZ-1:0] ic_req_pc_out;
    logic             ic_req_epoch_out;

    // PC generator side: issues requests, observes acceptance
    modport master (
        output ic_req_valid_out,
        output ic_req_addr_out,
        output ic_req_pc_out,
        output ic_req_epoch_out,
        input  ic_req_ready_in
    );

    // Instruction memory side: receives requests, signals acceptance
    modport slave (
        input  ic_req_valid_out,
        input  ic_req_addr_out,
        input  ic_req_pc_out,
        input  ic_req_epoch_out,
        output ic_req_ready_in
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator with sequential prediction, redirects and epoch tagging (option: PCG_MIS_CHK_EN)
module fetch_pc_gen #(
    parameter int               PC_SZ    = 32,
    parameter logic [PC_SZ-1:0] RESET_PC = '0
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             br_valid_in,
    input  logic [PC_SZ-1:0] br_pc_in,
    input  logic [PC_SZ-1:0] no_br_pc_in,
    input  logic             trap_valid_in,
    input  logic [PC_SZ-1:0] trap_pc_in,
    fetch_pc_gen_if.master   ic,
    output logic             flush_out,
    output logic             mis_out,
    output logic [PC_SZ-1:0] mis_addr_out
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH     = 2'd1,
        S_WAIT_TRAP = 2'd2
    } state_t;

    localparam logic [PC_SZ-3:0] WORD_INC = {{(PC_SZ-3){1'b0}}, 1'b1};

    state_t           state;
    logic [PC_SZ-1:0] pc_q;
    logic             epoch_q;
    logic             pend_v;
    logic [PC_SZ-1:0] pend_pc;
    logic             valid_q;
    logic             flush_q;

    logic             br_taken;
    logic             rd;
    logic [PC_SZ-1:0] rd_raw;
    logic [PC_SZ-1:0] rd_tgt;
    logic             mis_hit;
    logic [PC_SZ-1:0] seq_pc;

    // A branch only redirects when its outcome differs from fall-through; traps always redirect and win
    always_comb begin
        br_taken = br_valid_in && (br_pc_in != no_br_pc_in);
        rd       = trap_valid_in || br_taken;
        rd_raw   = trap_valid_in ? trap_pc_in : br_pc_in;
`ifdef PCG_MIS_CHK_EN
        rd_tgt   = rd_raw;
        mis_hit  = br_taken && !trap_valid_in && br_pc_in[0];
`else
        rd_tgt   = {rd_raw[PC_SZ-1:1], 1'b0};
        mis_hit  = 1'b0;
`endif
        seq_pc   = {pc_q[PC_SZ-1:2] + WORD_INC, 2'b00};
    end

    // Fetch FSM, PC/epoch update and buffering of redirects that arrive while a request is stalled
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
            pend_v  <= 1'b0;
            pend_pc <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_FETCH;
                    valid_q <= 1'b1;
                    if (rd && !mis_hit) begin
                        pc_q    <= rd_tgt;
                        epoch_q <= ~epoch_q;
                        flush_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mis_hit) begin
                        // Misaligned branch target is dropped; fetch stops until the trap arrives
                        state   <= S_WAIT_TRAP;
                        valid_q <= 1'b0;
                        pend_v  <= 1'b0;
                    end else if (ic.ic_req_ready_in) begin
                        pend_v <= 1'b0;
                        if (pend_v) begin
                            pc_q    <= pend_pc;
                            epoch_q <= ~epoch_q;
                            flush_q <= 1'b1;
                        end else if (rd) begin
                            pc_q    <= rd_tgt;
                            epoch_q <= ~epoch_q;
                            flush_q <= 1'b1;
                        end else begin
                            pc_q <= seq_pc;
                        end
                    end else if (rd) begin
                        // Request is stalled: its address must hold, so remember the newest redirect
                        pend_v  <= 1'b1;
                        pend_pc <= rd_tgt;
                    end
                end
                S_WAIT_TRAP: begin
                    if (trap_valid_in) begin
                        state   <= S_FETCH;
                        valid_q <= 1'b1;
                        pc_q    <= rd_tgt;
                        epoch_q <= ~epoch_q;
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCG_MIS_CHK_EN
    logic             mis_q;
    logic [PC_SZ-1:0] mis_addr_q;

    // One-cycle misaligned pulse; the offending address is held for the trap handler
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q <= 1'b0;
            if (state == S_FETCH && mis_hit) begin
                mis_q      <= 1'b1;
                mis_addr_q <= br_pc_in;
            end
        end
    end

    assign mis_out      = mis_q;
    assign mis_addr_out = mis_addr_q;
`else
    assign mis_out      = 1'b0;
    assign mis_addr_out = '0;
`endif

    assign ic.ic_req_valid_out = valid_q;
    assign ic.ic_req_addr_out  = {pc_q[PC_SZ-1:2], 2'b00};
    assign ic.ic_req_pc_out    = pc_q;
    assign ic.ic_req_epoch_out = epoch_q;
    assign flush_out           = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - directed self-checking bench for fetch_pc_gen
module tb_fetch_pc_gen;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        br_valid_in;
    logic [31:0] br_pc_in;
    logic [31:0] no_br_pc_in;
    logic        trap_valid_in;
    logic [31:0] trap_pc_in;
    logic        flush_out;
    logic        mis_out;
    logic [31:0] mis_addr_out;

    int tests = 0;
    int fails = 0;

    fetch_pc_gen_if #(.PC_SZ(32)) ic ();

    fetch_pc_gen #(.PC_SZ(32), .RESET_PC(32'h0000_0100)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .br_valid_in   (br_valid_in),
        .br_pc_in      (br_pc_in),
        .no_br_pc_in   (no_br_pc_in),
        .trap_valid_in (trap_valid_in),
        .trap_pc_in    (trap_pc_in),
        .ic            (ic),
        .flush_out     (flush_out),
        .mis_out       (mis_out),
        .mis_addr_out  (mis_addr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_br(input logic v, input logic [31:0] tgt, input logic [31:0] fall);
        br_valid_in = v;
        br_pc_in    = tgt;
        no_br_pc_in = fall;
    endtask

    task automatic test_reset();
        reset_in = 1'b0; ic.ic_req_ready_in = 1'b0;
        set_br(1'b0, 32'h0, 32'h0); trap_valid_in = 1'b0; trap_pc_in = 32'h0;
        step(); step();
        tests++; if (ic.ic_req_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h exp 0", ic.ic_req_valid_out); end
        tests++; if (ic.ic_req_addr_out !== 32'h100) begin fails++; $display("FAIL reset_addr got %0h exp 100", ic.ic_req_addr_out); end
        tests++; if (ic.ic_req_pc_out !== 32'h100) begin fails++; $display("FAIL reset_pc got %0h exp 100", ic.ic_req_pc_out); end
        tests++; if (ic.ic_req_epoch_out !== 1'b0) begin fails++; $display("FAIL reset_epoch got %0h exp 0", ic.ic_req_epoch_out); end
        tests++; if ({flush_out, mis_out} !== 2'b00) begin fails++; $display("FAIL reset_flush_mis got %0b exp 00", {flush_out, mis_out}); end
        tests++; if (mis_addr_out !== 32'h0) begin fails++; $display("FAIL reset_mis_addr got %0h exp 0", mis_addr_out); end
        reset_in = 1'b1; ic.ic_req_ready_in = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            else step();
            tests++; if (ic.ic_req_valid_out !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %0h exp 1", i, ic.ic_req_valid_out); end
            tests++; if (ic.ic_req_addr_out !== exp_addr[i]) begin fails++; $display("FAIL seq_addr[%0d] got %0h exp %0h", i, ic.ic_req_addr_out, exp_addr[i]); end
            tests++; if (ic.ic_req_epoch_out !== 1'b0) begin fails++; $display("FAIL seq_epoch[%0d] got %0h exp 0", i, ic.ic_req_epoch_out); end
        end
    endtask

    task automatic test_branch();
        set_br(1'b1, 32'h200, 32'h10C);
        step();
        set_br(1'b0, 32'h0, 32'h0);
        tests++; if (ic.ic_req_addr_out !== 32'h200) begin fails++; $display("FAIL br_addr got %0h exp 200", ic.ic_req_addr_out); end
        tests++; if (ic.ic_req_epoch_out !== 1'b1) begin fails++; $display("FAIL br_epoch got %0h exp 1", ic.ic_req_epoch_out); end
        tests++; if (flush_out !== 1'b1) begin fails++; $display("FAIL br_flush got %0h exp 1", flush_out); end
        step();
        tests++; if (ic.ic_req_addr_out !== 32'h204) begin fails++; $display("FAIL br_seq_addr got %0h exp 204", ic.ic_req_addr_out); end
        tests++; if (flush_out !== 1'b0) begin fails++; $display("FAIL br_flush_pulse got %0h exp 0", flush_out); end
        set_br(1'b1, 32'h208, 32'h208);
        step();
        set_br(1'b0, 32'h0, 32'h0);
        tests++; if (ic.ic_req_addr_out !== 32'h208) begin fails++; $display("FAIL nt_addr got %0h exp 208", ic.ic_req_addr_out); end
        tests++; if ({flush_out, ic.ic_req_epoch_out} !== 2'b01) begin fails++; $display("FAIL nt_flush_epoch got %0b exp 01", {flush_out, ic.ic_req_epoch_out}); end
    endtask

    task automatic test_stall();
        set_br(1'b1, 32'h108, 32'h20C);
        step();
        tests++; if ({ic.ic_req_addr_out, ic.ic_req_epoch_out} !== {32'h108, 1'b0}) begin fails++; $display("FAIL st_setup got %0h/%0h exp 108/0", ic.ic_req_addr_out, ic.ic_req_epoch_out); end
        ic.ic_req_ready_in = 1'b0;
        set_br(1'b1, 32'h300, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            step();
            set_br(1'b0, 32'h0, 32'h0);
            tests++; if ({ic.ic_req_addr_out, ic.ic_req_pc_out} !== {32'h108, 32'h108}) begin fails++; $display("FAIL st_hold[%0d] got %0h/%0h exp 108/108", i, ic.ic_req_addr_out, ic.ic_req_pc_out); end
            tests++; if ({ic.ic_req_epoch_out, flush_out, ic.ic_req_valid_out} !== 3'b001) begin fails++; $display("FAIL st_hold_ctl[%0d] got %0b exp 001", i, {ic.ic_req_epoch_out, flush_out, ic.ic_req_valid_out}); end
        end
        ic.ic_req_ready_in = 1'b1;
        step();
        tests++; if (ic.ic_req_addr_out !== 32'h300) begin fails++; $display("FAIL st_apply_addr got %0h exp 300", ic.ic_req_addr_out); end
        tests++; if ({ic.ic_req_epoch_out, flush_out} !== 2'b11) begin fails++; $display("FAIL st_apply_ctl got %0b exp 11", {ic.ic_req_epoch_out, flush_out}); end
    endtask

    task automatic test_priority();
        trap_valid_in = 1'b1; trap_pc_in = 32'h80;
        set_br(1'b1, 32'h400, 32'h304);
        step();
        trap_valid_in = 1'b0; set_br(1'b0, 32'h0, 32'h0);
        tests++; if (ic.ic_req_addr_out !== 32'h80) begin fails++; $display("FAIL pri_trap got %0h exp 80", ic.ic_req_addr_out); end
        tests++; if ({ic.ic_req_epoch_out, flush_out} !== 2'b01) begin fails++; $display("FAIL pri_ctl got %0b exp 01", {ic.ic_req_epoch_out, flush_out}); end
        ic.ic_req_ready_in = 1'b0;
        set_br(1'b1, 32'h500, 32'h84);
        step();
        set_br(1'b1, 32'h600, 32'h84);
        step();
        set_br(1'b0, 32'h0, 32'h0);
        tests++; if (ic.ic_req_addr_out !== 32'h80) begin fails++; $display("FAIL pri_hold got %0h exp 80", ic.ic_req_addr_out); end
        ic.ic_req_ready_in = 1'b1;
        step();
        tests++; if (ic.ic_req_addr_out !== 32'h600) begin fails++; $display("FAIL pri_newest got %0h exp 600", ic.ic_req_addr_out); end
        tests++; if ({ic.ic_req_epoch_out, flush_out} !== 2'b11) begin fails++; $display("FAIL pri_newest_ctl got %0b exp 11", {ic.ic_req_epoch_out, flush_out}); end
    endtask

    task automatic test_wrap();
        set_br(1'b1, 32'hFFFF_FFFC, 32'h604);
        step();
        set_br(1'b0, 32'h0, 32'h0);
        tests++; if (ic.ic_req_addr_out !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got %0h exp fffffffc", ic.ic_req_addr_out); end
        step();
        tests++; if ({ic.ic_req_addr_out, ic.ic_req_pc_out} !== 64'h0) begin fails++; $display("FAIL wrap_zero got %0h/%0h exp 0/0", ic.ic_req_addr_out, ic.ic_req_pc_out); end
        tests++; if ({ic.ic_req_epoch_out, flush_out} !== 2'b00) begin fails++; $display("FAIL wrap_ctl got %0b exp 00", {ic.ic_req_epoch_out, flush_out}); end
    endtask

    task automatic test_misaligned();
        set_br(1'b1, 32'h201, 32'h4);
        step();
`ifdef PCG_MIS_CHK_EN
        set_br(1'b1, 32'h700, 32'h4);
        tests++; if ({ic.ic_req_valid_out, mis_out} !== 2'b01) begin fails++; $display("FAIL mis_pulse got %0b exp 01", {ic.ic_req_valid_out, mis_out}); end
        tests++; if (mis_addr_out !== 32'h201) begin fails++; $display("FAIL mis_addr got %0h exp 201", mis_addr_out); end
        step();
        set_br(1'b0, 32'h0, 32'h0);
        tests++; if ({ic.ic_req_valid_out, mis_out, flush_out} !== 3'b000) begin fails++; $display("FAIL mis_wait got %0b exp 000", {ic.ic_req_valid_out, mis_out, flush_out}); end
        trap_valid_in = 1'b1; trap_pc_in = 32'h80;
        step();
        trap_valid_in = 1'b0;
        tests++; if ({ic.ic_req_valid_out, ic.ic_req_addr_out} !== {1'b1, 32'h80}) begin fails++; $display("FAIL mis_trap got %0h/%0h exp 1/80", ic.ic_req_valid_out, ic.ic_req_addr_out); end
        tests++; if ({ic.ic_req_epoch_out, flush_out} !== 2'b11) begin fails++; $display("FAIL mis_trap_ctl got %0b exp 11", {ic.ic_req_epoch_out, flush_out}); end
`else
        set_br(1'b0, 32'h0, 32'h0);
        tests++; if ({ic.ic_req_addr_out, ic.ic_req_pc_out} !== {32'h200, 32'h200}) begin fails++; $display("FAIL mis_clr got %0h/%0h exp 200/200", ic.ic_req_addr_out, ic.ic_req_pc_out); end
        tests++; if ({ic.ic_req_valid_out, mis_out, ic.ic_req_epoch_out, flush_out} !== 4'b1011) begin fails++; $display("FAIL mis_clr_ctl got %0b exp 1011", {ic.ic_req_valid_out, mis_out, ic.ic_req_epoch_out, flush_out}); end
        tests++; if (mis_addr_out !== 32'h0) begin fails++; $display("FAIL mis_addr_tied got %0h exp 0", mis_addr_out); end
`endif
    endtask

    task automatic test_reset_mid();
        ic.ic_req_ready_in = 1'b0;
        set_br(1'b1, 32'h900, 32'h4);
        step();
        set_br(1'b0, 32'h0, 32'h0);
        #2;
        reset_in = 1'b0;
        #1;
        tests++; if (ic.ic_req_valid_out !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %0h exp 0", ic.ic_req_valid_out); end
        tests++; if ({ic.ic_req_pc_out, ic.ic_req_epoch_out, flush_out} !== {32'h100, 2'b00}) begin fails++; $display("FAIL rstmid_state got %0h/%0b exp 100/00", ic.ic_req_pc_out, {ic.ic_req_epoch_out, flush_out}); end
        step();
        tests++; if (ic.ic_req_valid_out !== 1'b0) begin fails++; $display("FAIL rstmid_hold got %0h exp 0", ic.ic_req_valid_out); end
        reset_in = 1'b1;
        ic.ic_req_ready_in = 1'b1;
        step();
        tests++; if ({ic.ic_req_valid_out, ic.ic_req_addr_out} !== {1'b1, 32'h100}) begin fails++; $display("FAIL rstmid_first got %0h/%0h exp 1/100", ic.ic_req_valid_out, ic.ic_req_addr_out); end
        step();
        tests++; if ({ic.ic_req_addr_out, ic.ic_req_epoch_out, flush_out} !== {32'h104, 2'b00}) begin fails++; $display("FAIL rstmid_pend_cleared got %0h/%0b exp 104/00", ic.ic_req_addr_out, {ic.ic_req_epoch_out, flush_out}); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_priority();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
